training_sequencer: RTL
=======================

TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 SHALL have parameter num_train_examples, default 600, meaning training-set size (indices 0..num_train_examples-1).
REQ-002 SHALL have parameter num_test_examples, default 400, meaning test-set size (indices num_train_examples..num_train_examples+num_test_examples-1).
REQ-003 SHALL have parameter num_epochs, default 10, meaning train+eval passes before the test phase.
REQ-004 SHALL have parameter output_units, default 1, meaning gradient vector length.
REQ-005 SHALL use one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle run request.
REQ-009 SHALL have port prediction, input, sfp, perceptron output for the example driven one cycle earlier.
REQ-010 SHALL have port expected, input, sfp, label for the example currently driven.
REQ-011 SHALL have port example, output, int, dataset index to the data source.
REQ-012 SHALL have port training, output, 1, weight-update enable to the perceptron.
REQ-013 SHALL have port error_gradient_next_layer, output, sfp[output_units], BCE loss gradient.
REQ-014 SHALL have port epoch, output, int, current epoch number.
REQ-015 SHALL have ports busy (output, 1, run in progress), done (output, 1, run finished) and correct_count (output, int, test hits).

Function
REQ-016 SHALL implement FSM states IDLE, TRAIN, EVAL, TEST, DRAIN and DONE.
REQ-017 SHALL move from IDLE or DONE to TRAIN on start=1, clearing epoch, example and correct_count; if num_epochs=0, it SHALL go directly to TEST.
REQ-018 SHALL ignore start while busy=1.
REQ-019 TRAIN SHALL drive training=1 and example=0..num_train_examples-1 at one index per cycle, then enter EVAL with example=0.
REQ-020 EVAL SHALL drive training=0 and sweep example 0..num_train_examples-1, one per cycle.
REQ-021 At the end of EVAL, the FSM SHALL increment epoch and go to TRAIN, or go to TEST when epoch+1 = num_epochs.
REQ-022 TEST SHALL drive training=0 and example=num_train_examples..num_train_examples+num_test_examples-1, one per cycle.
REQ-023 After the last TEST index, the FSM SHALL spend exactly one DRAIN cycle to score the final prediction, then enter DONE.
REQ-024 SHALL register expected into expected_q each cycle so scoring pairs prediction with the label of the previous cycle's example (1-cycle perceptron latency).
REQ-025 During the TEST cycles after the first, and during DRAIN, correct_count SHALL increment when (prediction < HALF) == (expected_q < HALF), using signed sfp compare.
REQ-026 SHALL compute every element of error_gradient_next_layer as -(sfp_div(expected_q, p) - sfp_div(ONE-expected_q, ONE-p)), with p = sfp_add(prediction, epsilon), using sfp_sub/sfp_add/sfp_div only, and register it (1-cycle latency) in all states.
REQ-027 SHALL hold busy=1 in TRAIN, EVAL, TEST and DRAIN.
REQ-028 SHALL hold done=1 in DONE until the next start or rst.
REQ-029 SHALL hold example, epoch and correct_count stable in IDLE and DONE.
REQ-030 SHALL keep example inside the currently active set and never advance it past the last index of that set.

Reset
REQ-031 rst SHALL force, at the next edge and regardless of state (including mid-run), state=IDLE, example=0, epoch=0, training=0, busy=0, done=0, correct_count=0 and error_gradient_next_layer=all 0.
REQ-032 rst SHALL take priority over start in the same cycle.

Verification
REQ-033 Params train=4, test=3, epochs=2; pulse start -> busy rises the next cycle, done rises 20 cycles after busy, example sequence 0..3,0..3,0..3,0..3,4,5,6.
REQ-034 Same params -> training=1 for exactly 8 cycles, in two 4-cycle bursts; epoch reads 0 then 1.
REQ-035 prediction=expected_q=ONE on all test cycles -> correct_count=3; prediction=0 with expected_q=ONE -> correct_count=0.
REQ-036 prediction=HALF-epsilon, expected=0 -> gradient equals reference sfp formula, appearing exactly one cycle later.
REQ-037 rst asserted mid-EVAL -> all outputs reach reset values at the next edge; a later start restarts at TRAIN, example=0, epoch=0.
REQ-038 num_epochs=0 -> first driven example=4 (TEST), training never 1; start pulsed while busy -> no effect on sequence.

Source files
------------

// File: rtl/training_sequencer.sv
// Dataset sequencer for perceptron training: sweeps train/eval epochs, then a test pass,
// scoring test predictions and producing the BCE loss gradient in signed fixed point.
module training_sequencer #(
  parameter int num_train_examples = 600,
  parameter int num_test_examples  = 400,
  parameter int num_epochs         = 10,
  parameter int output_units       = 1,
  parameter int DATA_W             = 16,
  parameter int FRAC_W             = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic signed [DATA_W-1:0]         prediction,
  input  logic signed [DATA_W-1:0]         expected,
  output logic [31:0]                      example,
  output logic                             training,
  output logic [output_units*DATA_W-1:0]   error_gradient_next_layer,
  output logic [31:0]                      epoch,
  output logic                             busy,
  output logic                             done,
  output logic [31:0]                      correct_count
);

  localparam int WIDE = 2*DATA_W + 2;
  localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] HALF    = DATA_W'(1 << (FRAC_W-1));
  localparam logic signed [DATA_W-1:0] EPSILON = DATA_W'(1);
  localparam logic signed [DATA_W-1:0] MAXV    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MINV    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [31:0] TRAIN_LAST = 32'(num_train_examples - 1);
  localparam logic [31:0] TEST_FIRST = 32'(num_train_examples);
  localparam logic [31:0] TEST_LAST  = 32'(num_train_examples + num_test_examples - 1);
  localparam logic [31:0] EPOCH_LAST = 32'(num_epochs - 1);

  typedef enum logic [2:0] {IDLE, TRAIN, EVAL, TEST, DRAIN, DONE} state_t;

  function automatic logic signed [DATA_W-1:0] sfp_sat(input logic signed [WIDE-1:0] x);
    logic signed [WIDE-1:0] hi, lo;
    hi = {{(WIDE-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = ~hi;
    if (x > hi)      return MAXV;
    else if (x < lo) return MINV;
    else             return x[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sfp_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    return sfp_sat(WIDE'(a) + WIDE'(b));
  endfunction

  function automatic logic signed [DATA_W-1:0] sfp_sub(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    return sfp_sat(WIDE'(a) - WIDE'(b));
  endfunction

  // Division by zero saturates toward the sign of the numerator.
  function automatic logic signed [DATA_W-1:0] sfp_div(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    logic signed [WIDE-1:0] num, den;
    if (b == '0) return a[DATA_W-1] ? MINV : MAXV;
    num = WIDE'(a) <<< FRAC_W;
    den = WIDE'(b);
    return sfp_sat(num / den);
  endfunction

  state_t                     state_q;
  logic [31:0]                example_q, epoch_q, count_q;
  logic                       training_q, busy_q, done_q;
  logic signed [DATA_W-1:0]   expected_q;
  logic [output_units*DATA_W-1:0] grad_q;
  logic signed [DATA_W-1:0]   p_d, grad_d;
  logic                       hit_d;

  always_comb begin
    p_d    = sfp_add(prediction, EPSILON);
    grad_d = sfp_sub('0, sfp_sub(sfp_div(expected_q, p_d),
                                 sfp_div(sfp_sub(ONE, expected_q), sfp_sub(ONE, p_d))));
    hit_d  = ((prediction < HALF) == (expected_q < HALF));
  end

  always_ff @(posedge clk) begin
    expected_q <= expected;
    if (rst) begin
      state_q    <= IDLE;
      example_q  <= '0;
      epoch_q    <= '0;
      count_q    <= '0;
      training_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      grad_q     <= '0;
    end else begin
      for (int u = 0; u < output_units; u++) grad_q[u*DATA_W +: DATA_W] <= grad_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            epoch_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            if (num_epochs == 0) begin
              state_q    <= TEST;
              example_q  <= TEST_FIRST;
              training_q <= 1'b0;
            end else begin
              state_q    <= TRAIN;
              example_q  <= '0;
              training_q <= 1'b1;
            end
          end
        end
        TRAIN: begin
          if (example_q == TRAIN_LAST) begin
            state_q    <= EVAL;
            example_q  <= '0;
            training_q <= 1'b0;
          end else begin
            example_q <= example_q + 32'd1;
          end
        end
        EVAL: begin
          if (example_q == TRAIN_LAST) begin
            if (epoch_q == EPOCH_LAST) begin
              state_q   <= TEST;
              example_q <= TEST_FIRST;
            end else begin
              state_q    <= TRAIN;
              epoch_q    <= epoch_q + 32'd1;
              example_q  <= '0;
              training_q <= 1'b1;
            end
          end else begin
            example_q <= example_q + 32'd1;
          end
        end
        TEST: begin
          // The first test cycle still sees the prediction for the last eval example.
          if (example_q != TEST_FIRST && hit_d) count_q <= count_q + 32'd1;
          if (example_q == TEST_LAST) state_q <= DRAIN;
          else                        example_q <= example_q + 32'd1;
        end
        DRAIN: begin
          if (hit_d) count_q <= count_q + 32'd1;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign example                   = example_q;
  assign training                  = training_q;
  assign epoch                     = epoch_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign correct_count             = count_q;
  assign error_gradient_next_layer = grad_q;

endmodule
